commit_unit: RTL and testbench

- In-order writeback/commit stage between execute/LSU and the register file.
- Accepts completed instructions through a valid/ready handshake and buffers them in a small FIFO.
- Retires at most one instruction per cycle. For each retirement it drives the commit write port (commit_valid/wena/waddr/wdata), which updates architectural registers and clears the scoreboard Busy bit.
- Detects ebreak at retirement and halts the core.

---
 rtl/commit_unit.sv | 158 +++++++++++++++
 tb/tb_commit_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order commit stage: small FIFO, one retirement per cycle, ebreak halt
// Optional retired/stall performance counters are built when COMMIT_PERF_EN is defined.
module commit_unit #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            exec_valid_pre,
   output logic            commit_ready_pre,
   input  logic            exec_wena_i,
   input  logic [4:0]      exec_waddr_i,
   input  logic [XLEN-1:0] exec_wdata_i,
   input  logic [XLEN-1:0] exec_pc_i,
   input  logic            exec_ebreak_i,
   output logic            commit_valid_o,
   output logic            commit_wena_o,
   output logic [4:0]      commit_waddr_o,
   output logic [XLEN-1:0] commit_wdata_o,
   output logic [XLEN-1:0] commit_pc_o,
   output logic            halt_o
`ifdef COMMIT_PERF_EN
   ,
   output logic [63:0]     retired_cnt_o,
   output logic [31:0]     stall_cnt_o
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic            r_wena_q   [DEPTH];
   logic [4:0]      r_waddr_q  [DEPTH];
   logic [XLEN-1:0] r_wdata_q  [DEPTH];
   logic [XLEN-1:0] r_pc_q     [DEPTH];
   logic            r_ebreak_q [DEPTH];

   logic w_push;
   logic w_pop;

   // Ready is held low while reset is asserted so nothing looks acceptable mid-reset.
   assign commit_ready_pre = !reset && (r_state == ST_RUN) && (r_count < DEPTH_C);
   assign w_push           = exec_valid_pre && commit_ready_pre;
   assign w_pop            = (r_state == ST_RUN) && (r_count != '0);
   assign halt_o           = (r_state == ST_HALT);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_pop && r_ebreak_q[r_head]) begin
               w_state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Payload storage needs no reset: occupancy is tracked entirely by r_count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_wena_q[r_tail]   <= exec_wena_i && (exec_waddr_i != 5'd0);
         r_waddr_q[r_tail]  <= exec_waddr_i;
         r_wdata_q[r_tail]  <= exec_wdata_i;
         r_pc_q[r_tail]     <= exec_pc_i;
         r_ebreak_q[r_tail] <= exec_ebreak_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Commit port is fully registered; the register file samples it on the falling edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         commit_valid_o <= 1'b0;
         commit_wena_o  <= 1'b0;
         commit_waddr_o <= '0;
         commit_wdata_o <= '0;
         commit_pc_o    <= '0;
      end else if (w_pop) begin
         commit_valid_o <= 1'b1;
         commit_wena_o  <= r_wena_q[r_head];
         commit_waddr_o <= r_waddr_q[r_head];
         commit_wdata_o <= r_wdata_q[r_head];
         commit_pc_o    <= r_pc_q[r_head];
      end else begin
         commit_valid_o <= 1'b0;
      end
   end

`ifdef COMMIT_PERF_EN
   logic [63:0] r_retired_cnt;
   logic [31:0] r_stall_cnt;

   // Counting on the pop edge keeps the count aligned with the commit pulse, ebreak included.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_retired_cnt <= '0;
         r_stall_cnt   <= '0;
      end else begin
         if (w_pop) begin
            r_retired_cnt <= r_retired_cnt + 64'd1;
         end
         if (exec_valid_pre && !commit_ready_pre && (r_state == ST_RUN)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign retired_cnt_o = r_retired_cnt;
   assign stall_cnt_o   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - randomized bench for commit_unit against a queue-based reference model
// Build with COMMIT_PERF_EN defined to also check the retired-instruction counter.
module tb_commit_unit;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   logic            clock;
   logic            reset;
   logic            exec_valid_pre;
   logic            commit_ready_pre;
   logic            exec_wena_i;
   logic [4:0]      exec_waddr_i;
   logic [XLEN-1:0] exec_wdata_i;
   logic [XLEN-1:0] exec_pc_i;
   logic            exec_ebreak_i;
   logic            commit_valid_o;
   logic            commit_wena_o;
   logic [4:0]      commit_waddr_o;
   logic [XLEN-1:0] commit_wdata_o;
   logic [XLEN-1:0] commit_pc_o;
   logic            halt_o;
`ifdef COMMIT_PERF_EN
   logic [63:0]     retired_cnt_o;
   logic [31:0]     stall_cnt_o;
`endif

   commit_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock            (clock),
      .reset            (reset),
      .exec_valid_pre   (exec_valid_pre),
      .commit_ready_pre (commit_ready_pre),
      .exec_wena_i      (exec_wena_i),
      .exec_waddr_i     (exec_waddr_i),
      .exec_wdata_i     (exec_wdata_i),
      .exec_pc_i        (exec_pc_i),
      .exec_ebreak_i    (exec_ebreak_i),
      .commit_valid_o   (commit_valid_o),
      .commit_wena_o    (commit_wena_o),
      .commit_waddr_o   (commit_waddr_o),
      .commit_wdata_o   (commit_wdata_o),
      .commit_pc_o      (commit_pc_o),
      .halt_o           (halt_o)
`ifdef COMMIT_PERF_EN
      ,
      .retired_cnt_o    (retired_cnt_o),
      .stall_cnt_o      (stall_cnt_o)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic            wena;
      logic [4:0]      waddr;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] pc;
      logic            ebreak;
   } ent_t;

   ent_t    m_q[$];
   ent_t    m_exp;
   logic    m_commit;
   logic    m_halt;
   longint  m_retired;
   int      n_checks;
   int      n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("valid", 64'(commit_valid_o), 64'(m_commit));
      if (m_commit) begin
         chk("wena",  64'(commit_wena_o),  64'(m_exp.wena && (m_exp.waddr != 5'd0)));
         chk("waddr", 64'(commit_waddr_o), 64'(m_exp.waddr));
         chk("wdata", 64'(commit_wdata_o), 64'(m_exp.wdata));
         chk("pc",    64'(commit_pc_o),    64'(m_exp.pc));
      end
      chk("halt", 64'(halt_o), 64'(m_halt));
`ifdef COMMIT_PERF_EN
      chk("retired_cnt", retired_cnt_o, 64'(m_retired));
`endif
   endtask

   // One clock: drive inputs, check ready, advance model across the edge, check outputs.
   task automatic cycle(input logic v, input logic we, input logic [4:0] wa,
                        input logic [XLEN-1:0] wd, input logic [XLEN-1:0] pc, input logic eb);
      logic exp_ready;
      ent_t e;
      exec_valid_pre = v;
      exec_wena_i    = we;
      exec_waddr_i   = wa;
      exec_wdata_i   = wd;
      exec_pc_i      = pc;
      exec_ebreak_i  = eb;
      exp_ready = !m_halt && (m_q.size() < DEPTH);
      #1;
      chk("ready", 64'(commit_ready_pre), 64'(exp_ready));
      m_commit = 1'b0;
      if (!m_halt && m_q.size() > 0) begin
         m_exp    = m_q.pop_front();
         m_commit = 1'b1;
         m_retired++;
         if (m_exp.ebreak) m_halt = 1'b1;
      end
      if (v && exp_ready) begin
         e.wena = we; e.waddr = wa; e.wdata = wd; e.pc = pc; e.ebreak = eb;
         m_q.push_back(e);
      end
      @(posedge clock);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      exec_valid_pre = 1'b0;
      @(posedge clock);
      #1;
      m_q.delete();
      m_halt    = 1'b0;
      m_commit  = 1'b0;
      m_retired = 0;
      chk("rst_valid", 64'(commit_valid_o), 64'd0);
      chk("rst_wena",  64'(commit_wena_o),  64'd0);
      chk("rst_waddr", 64'(commit_waddr_o), 64'd0);
      chk("rst_wdata", 64'(commit_wdata_o), 64'd0);
      chk("rst_pc",    64'(commit_pc_o),    64'd0);
      chk("rst_halt",  64'(halt_o),         64'd0);
`ifdef COMMIT_PERF_EN
      chk("rst_retired", retired_cnt_o, 64'd0);
`endif
      reset = 1'b0;
      #1;
      chk("rst_ready", 64'(commit_ready_pre), 64'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_halt   = 1'b0;
      m_commit = 1'b0;
      m_retired = 0;
      reset          = 1'b1;
      exec_valid_pre = 1'b0;
      exec_wena_i    = 1'b0;
      exec_waddr_i   = '0;
      exec_wdata_i   = '0;
      exec_pc_i      = '0;
      exec_ebreak_i  = 1'b0;
      @(posedge clock);
      #1;
      do_reset();

      // single write, then the pulse must drop
      cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h8000_0000, 1'b0);
      idle(3);

      // back-to-back stream of 8
      for (int i = 1; i <= 8; i++)
         cycle(1'b1, 1'b1, 5'(i), $urandom, 32'h8000_0000 + 32'(4 * i), 1'b0);
      idle(2);

      // x0 write
      cycle(1'b1, 1'b1, 5'd0, 32'h1234, 32'h8000_0100, 1'b0);
      idle(2);

      // ebreak: two commits, third frozen, halt sticks
      do_reset();
      cycle(1'b1, 1'b1, 5'd10, 32'h0, 32'h8000_0000, 1'b0);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 32'h8000_0004, 1'b1);
      cycle(1'b1, 1'b1, 5'd11, 32'h55, 32'h8000_0008, 1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b1, 5'd12, 32'h66, 32'h8000_000C, 1'b0);
      chk("halt_sticky", 64'(halt_o), 64'd1);
`ifdef COMMIT_PERF_EN
      chk("retired_after_ebreak", retired_cnt_o, 64'd2);
`endif
      do_reset();

      // reset with one entry buffered: the pending pulse is suppressed
      cycle(1'b1, 1'b1, 5'd7, 32'hABCD, 32'h8000_0200, 1'b0);
      do_reset();
      idle(2);

      // randomized segments with occasional ebreak
      for (int seg = 0; seg < 8; seg++) begin
         do_reset();
         for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom), $urandom,
                  $urandom, 1'($urandom_range(0, 40) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
